// File: rtl/seq_divider64_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_divider64_if                                              |
// | Purpose  : start/done request bus between the ALU issue logic and the    |
// |            sequential divider.                                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface seq_divider64_if #(
  parameter int DATA_WIDTH = 64
);
  logic                  start;
  logic                  signed_op;
  logic [DATA_WIDTH-1:0] lhs;
  logic [DATA_WIDTH-1:0] rhs;
  logic                  busy;
  logic                  done;
  logic [DATA_WIDTH-1:0] quo;
  logic [DATA_WIDTH-1:0] rem;
  logic                  dbz;

  // Requester side: issues operations, observes results.
  modport master (
    output start, signed_op, lhs, rhs,
    input  busy, done, quo, rem, dbz
  );

  // Divider side.
  modport slave (
    input  start, signed_op, lhs, rhs,
    output busy, done, quo, rem, dbz
  );
endinterface
`default_nettype wire

// File: rtl/seq_divider64.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seq_divider64                                                 |
// | Purpose  : Multi-cycle radix-2 restoring divider, signed or unsigned.    |
// |            One quotient bit per cycle on unsigned magnitudes, sign fix   |
// |            applied in a final cycle. Divide-by-zero completes in 1 edge. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seq_divider64 #(
  parameter int DATA_WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  seq_divider64_if.slave   bus
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [W-1:0]     ONE_W    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [W-1:0]     dvd_q,   dvd_d;    // dividend magnitude, quotient bits shift in at LSB
  logic [W-1:0]     div_q,   div_d;    // divisor magnitude
  logic [W-1:0]     prem_q,  prem_d;   // partial remainder, always < divisor
  logic [W-1:0]     quo_q,   quo_d;
  logic [W-1:0]     rem_q,   rem_d;
  logic             qneg_q,  qneg_d;
  logic             rneg_q,  rneg_d;
  logic             dbz_q,   dbz_d;
  logic             done_q,  done_d;

  logic             lhs_neg, rhs_neg;
  logic [W-1:0]     lhs_abs, rhs_abs;
  logic [W:0]       shifted;
  logic [W:0]       trial;
  logic             trial_ok;

  // Adder in subtract mode: a + ~b + 1, one bit wider than the operands.
  function automatic logic [W:0] add_w1(input logic [W:0] a, input logic [W:0] b,
                                        input logic cin);
    return a + b + {{W{1'b0}}, cin};
  endfunction

  // Operand magnitudes and trial subtraction of the current iteration.
  // MIN negates to itself, which read unsigned is exactly 2^(W-1).
  // Because prem < divisor, shifted - divisor lies in (-2^W, 2^W), so
  // bit W of the W+1-bit difference is a reliable sign.
  always_comb begin
    lhs_neg  = bus.signed_op & bus.lhs[W-1];
    rhs_neg  = bus.signed_op & bus.rhs[W-1];
    lhs_abs  = lhs_neg ? (~bus.lhs + ONE_W) : bus.lhs;
    rhs_abs  = rhs_neg ? (~bus.rhs + ONE_W) : bus.rhs;
    shifted  = {prem_q, dvd_q[W-1]};
    trial    = add_w1(shifted, {1'b1, ~div_q}, 1'b1);
    trial_ok = ~trial[W];
  end

  // Next-state and datapath control: IDLE -> ITER -> FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    div_d   = div_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.rhs == '0) begin
            quo_d  = '1;
            rem_d  = bus.lhs;
            dbz_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            dvd_d   = lhs_abs;
            div_d   = rhs_abs;
            qneg_d  = lhs_neg ^ rhs_neg;
            rneg_d  = lhs_neg;
            prem_d  = '0;
            cnt_d   = CNT_LAST;
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        prem_d = trial_ok ? trial[W-1:0] : shifted[W-1:0];
        dvd_d  = {dvd_q[W-2:0], trial_ok};
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_FIX: begin
        quo_d   = qneg_q ? (~dvd_q + ONE_W) : dvd_q;
        rem_d   = rneg_q ? (~prem_q + ONE_W) : prem_q;
        dbz_d   = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      div_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      div_q   <= div_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;
  assign bus.dbz  = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider64.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seq_divider64                                              |
// | Purpose  : Scoreboard bench for seq_divider64: directed corner cases and |
// |            random operands against an arithmetic reference model.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seq_divider64;

  localparam int W   = 64;
  localparam int LAT = W + 1;
  localparam logic [W-1:0] MIN = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_divider64_if #(.DATA_WIDTH(W)) bus ();
  seq_divider64 #(.DATA_WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [W-1:0] quo;
    logic [W-1:0] rem;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  // Edge counter used to check result latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Reference: plain Verilog division with the divider's defined corner results.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    e.dbz = 1'b0;
    e.cyc = 0;
    if (b == '0) begin
      e.quo = '1;
      e.rem = a;
      e.dbz = 1'b1;
    end else if (s && a == MIN && b == '1) begin
      e.quo = MIN;
      e.rem = '0;
    end else if (s) begin
      e.quo = $signed(a) / $signed(b);
      e.rem = $signed(a) % $signed(b);
    end else begin
      e.quo = a / b;
      e.rem = a % b;
    end
    return e;
  endfunction

  // Drive one start cycle; optionally record the expected result and its arrival cycle.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input bit expect_it);
    exp_t e;
    e     = model(a, b, s);
    e.cyc = cyc + ((b == '0) ? 1 : (LAT + 1));
    bus.lhs       = a;
    bus.rhs       = b;
    bus.signed_op = s;
    bus.start     = 1'b1;
    if (expect_it) sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start     = 1'b0;
    bus.lhs       = {$urandom, $urandom};
    bus.rhs       = {$urandom, $urandom};
    bus.signed_op = ~s;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LAT + 10 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_timeout: done=0 expected 1", name);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: done=1 expected 0");
      end else begin
        e = sb.pop_front();
        check("quo", bus.quo, e.quo);
        check("rem", bus.rem, e.rem);
        check("dbz", W'(bus.dbz), W'(e.dbz));
        check("latency_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  initial begin
    logic [W-1:0] a, b;
    logic         s;
    int           mode;
    void'($urandom(777));
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.lhs       = '0;
    bus.rhs       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", W'(bus.busy), '0);
    check("reset_done", W'(bus.done), '0);
    check("reset_quo",  bus.quo, '0);
    check("reset_rem",  bus.rem, '0);
    check("reset_dbz",  W'(bus.dbz), '0);
    @(negedge clk);

    // Basic unsigned, then signed sign rules (issued back-to-back in done cycles).
    issue(64'd100, 64'd7, 1'b0, 1'b1);                     wait_done("u100_7");
    issue(64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b1, 1'b1);     wait_done("s_m100_7");
    issue(64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1, 1'b1);   wait_done("s_100_m7");
    // Divide by zero in both modes.
    issue(64'd5, 64'd0, 1'b0, 1'b1);                       wait_done("u_dbz");
    issue(64'd5, 64'd0, 1'b1, 1'b1);                       wait_done("s_dbz");
    // MIN / -1 in both modes.
    issue(MIN, '1, 1'b1, 1'b1);                            wait_done("s_min_m1");
    issue(MIN, '1, 1'b0, 1'b1);                            wait_done("u_min_ones");

    // A start pulse mid-iteration with new operands must be ignored.
    issue(64'd1000, 64'd3, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    bus.lhs   = 64'd77;
    bus.rhs   = 64'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("start_while_busy");

    // Reset mid-iteration discards the operation and clears the outputs.
    @(negedge clk);
    issue(64'd100, 64'd7, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", W'(bus.busy), '0);
    check("midrst_done", W'(bus.done), '0);
    check("midrst_quo",  bus.quo, '0);
    check("midrst_rem",  bus.rem, '0);
    check("midrst_dbz",  W'(bus.dbz), '0);
    repeat (LAT + 5) @(negedge clk);
    issue(64'd100, 64'd7, 1'b0, 1'b1);                     wait_done("after_rst");

    // Random operands in both modes with a bias toward corner divisors.
    for (int n = 0; n < 1000; n++) begin
      s    = 1'($urandom_range(0, 1));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = '0;
        1: b = '1;
        2: begin a = MIN; b = '1; end
        3: b = W'($urandom_range(1, 20));
        4, 5: b = b >> $urandom_range(0, W - 1);
        default: ;
      endcase
      issue(a, b, s, 1'b1);
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL results_outstanding: got %0d expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
